data_mem_responder: RTL

- Memory-side responder for the processor's load/store port.
- Accepts one byte/halfword/word request at a time over a valid/ready handshake.
- Inserts a fixed, parameterised number of wait states, then returns one response beat with read data and an error flag.
- Sits between the datapath load/store logic (the initiator) and word-organised backing storage. Gives the core a multi-cycle memory model with sign/zero-extended sub-word loads and byte-merged sub-word stores.

---
 rtl/data_mem_responder.sv | 78 +++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: load/store memory responder with fixed wait states and sub-word access.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [1:0]  BHW,
  input  logic        ExtendSign,
  output logic        RespValid,
  output logic [31:0] ReadData,
  output logic        RespError
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state, state_nx;
  logic [4:0] cnt;
  logic wr, ext;
  logic [31:0] addr, wdata;
  logic [1:0] bhw;
  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};
  logic commit, err;
  logic [4:0] sh;
  logic [31:0] word, mask, merged, shifted, loaded;
  // Counter holds WAIT_CYCLES+1 so the commit edge falls WAIT_CYCLES+1 edges after accept.
  always_comb begin
    commit = state == S_WAIT && cnt == 5'd1;
    state_nx = state == S_IDLE ? (ReqValid ? S_WAIT : S_IDLE) :
               state == S_WAIT ? (commit ? S_RESP : S_WAIT) : S_IDLE;
  end
  always_comb begin
    err = bhw == 2'd3 || (bhw == 2'd1 && addr[0]) || (bhw == 2'd2 && addr[1:0] != 2'd0) ||
          ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
    word = err ? '0 : mem[addr[AW+1:2]];
    sh = {addr[1:0], 3'b000};
    mask = bhw == 2'd0 ? 32'h0000_00ff << sh : bhw == 2'd1 ? 32'h0000_ffff << sh : '1;
    merged = (word & ~mask) | ((wdata << sh) & mask);
    shifted = word >> sh;
    loaded = bhw == 2'd0 ? {{24{ext & shifted[7]}}, shifted[7:0]} :
             bhw == 2'd1 ? {{16{ext & shifted[15]}}, shifted[15:0]} : word;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
      cnt <= '0;
      wr <= 1'b0;
      ext <= 1'b0;
      addr <= '0;
      wdata <= '0;
      bhw <= '0;
      ReadData <= '0;
      RespError <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && ReqValid) begin
        wr <= ReqWrite;
        ext <= ExtendSign;
        addr <= Address;
        wdata <= WriteData;
        bhw <= BHW;
        cnt <= 5'(WAIT_CYCLES + 1);
      end else if (state == S_WAIT) cnt <= cnt - 5'd1;
      if (commit) begin
        RespError <= err;
        if (err || !wr) ReadData <= loaded;
      end
    end
  end
  always_ff @(posedge Clk)
    if (!Reset && commit && wr && !err) mem[addr[AW+1:2]] <= merged;
  assign ReqReady = state == S_IDLE;
  assign RespValid = state == S_RESP;
endmodule
